// File: rtl/counter_mod_param.sv
// Parametrised modulo counter with prescaler, up/down, clear, clamped load and
// registered terminal-count / step pulses. Used for elevator timers and floor index.
module counter_mod_param #(
  parameter int WIDTH    = 16,
  parameter int MAX      = 65535,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             step
);

  localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX);
  localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] out_reg, out_next;
  logic [PW-1:0]    pre_reg, pre_next;
  logic             tc_reg, tc_next;
  logic             step_reg, step_next;

  always_comb begin
    out_next  = out_reg;
    pre_next  = pre_reg;
    tc_next   = 1'b0;
    step_next = 1'b0;
    if (clr) begin
      out_next = '0;
      pre_next = '0;
    end else if (load) begin
      out_next = (load_val > MAX_V) ? MAX_V : load_val;
      pre_next = '0;
    end else if (en) begin
      if (pre_reg != PRE_LAST) begin
        pre_next = pre_reg + PW'(1);
      end else begin
        pre_next  = '0;
        step_next = 1'b1;
        if (dir) begin
          // >= also recovers an out-of-range value by wrapping to zero
          if (out_reg >= MAX_V) begin
            out_next = '0;
            tc_next  = 1'b1;
          end else begin
            out_next = out_reg + WIDTH'(1);
          end
        end else begin
          if (out_reg == '0) begin
            out_next = MAX_V;
            tc_next  = 1'b1;
          end else begin
            out_next = out_reg - WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_reg  <= '0;
      pre_reg  <= '0;
      tc_reg   <= 1'b0;
      step_reg <= 1'b0;
    end else begin
      out_reg  <= out_next;
      pre_reg  <= pre_next;
      tc_reg   <= tc_next;
      step_reg <= step_next;
    end
  end

  assign out  = out_reg;
  assign tc   = tc_reg;
  assign step = step_reg;

endmodule

// File: tb/tb_counter_mod_param.sv
// Bench for counter_mod_param: three parameterisations driven from shared stimulus,
// each checked every cycle against an arithmetic reference model.
module tb_counter_mod_param;

  logic        clk;
  logic        rst;
  logic        en;
  logic        clr;
  logic        load;
  logic        dir;
  logic [15:0] load_val;

  logic [15:0] d0_out;
  logic        d0_tc, d0_step;
  logic [3:0]  d1_out;
  logic        d1_tc, d1_step;
  logic [3:0]  d2_out;
  logic        d2_tc, d2_step;

  int checks   = 0;
  int failures = 0;

  // reference model state, one slot per instance
  int p_max [3] = '{65535, 9, 9};
  int p_ps  [3] = '{1, 3, 1};
  int m_out [3];
  int m_cnt [3];
  bit m_tc  [3];
  bit m_step[3];

  counter_mod_param #(.WIDTH(16), .MAX(65535), .PRESCALE(1)) d0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .dir(dir), .out(d0_out), .tc(d0_tc), .step(d0_step)
  );

  counter_mod_param #(.WIDTH(4), .MAX(9), .PRESCALE(3)) d1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
    .load_val(load_val[3:0]), .dir(dir), .out(d1_out), .tc(d1_tc), .step(d1_step)
  );

  counter_mod_param #(.WIDTH(4), .MAX(9), .PRESCALE(1)) d2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load),
    .load_val(load_val[3:0]), .dir(dir), .out(d2_out), .tc(d2_tc), .step(d2_step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_out[k] = 0; m_cnt[k] = 0; m_tc[k] = 0; m_step[k] = 0;
    end
  endtask

  // one rising edge of behaviour, from the rules: clr > load > count
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int lv;
      lv = (k == 0) ? int'(load_val) : int'(load_val[3:0]);
      m_tc[k]   = 0;
      m_step[k] = 0;
      if (clr) begin
        m_out[k] = 0;
        m_cnt[k] = 0;
      end else if (load) begin
        m_out[k] = (lv > p_max[k]) ? p_max[k] : lv;
        m_cnt[k] = 0;
      end else if (en) begin
        m_cnt[k]++;
        if (m_cnt[k] == p_ps[k]) begin
          m_cnt[k]  = 0;
          m_step[k] = 1;
          if (dir) begin
            m_tc[k]  = (m_out[k] >= p_max[k]);
            m_out[k] = m_tc[k] ? 0 : m_out[k] + 1;
          end else begin
            m_tc[k]  = (m_out[k] == 0);
            m_out[k] = (m_out[k] + p_max[k]) % (p_max[k] + 1);
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("d0.out",  32'(d0_out),  32'(m_out[0]));
    chk("d0.tc",   32'(d0_tc),   32'(m_tc[0]));
    chk("d0.step", 32'(d0_step), 32'(m_step[0]));
    chk("d1.out",  32'(d1_out),  32'(m_out[1]));
    chk("d1.tc",   32'(d1_tc),   32'(m_tc[1]));
    chk("d1.step", 32'(d1_step), 32'(m_step[1]));
    chk("d2.out",  32'(d2_out),  32'(m_out[2]));
    chk("d2.tc",   32'(d2_tc),   32'(m_tc[2]));
    chk("d2.step", 32'(d2_step), 32'(m_step[2]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // reset raised between edges; outputs must clear before any clock edge
  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    $display("async reset: d1.out=%0d tc=%0d step=%0d", d1_out, d1_tc, d1_step);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int tc0;
    rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; dir = 1'b1; load_val = '0;
    model_reset();
    #12;
    compare_all();
    rst = 1'b0;

    // default instance wraps 65535 -> 0 exactly once in 70000 cycles
    en = 1'b1; dir = 1'b1;
    tc0 = 0;
    for (int i = 0; i < 70000; i++) begin
      tick();
      if (d0_tc) tc0++;
    end
    chk("d0.tc_count", 32'(tc0), 32'd1);
    $display("free run: d0.out=%0d tc pulses=%0d", d0_out, tc0);

    // down count from reset, then direction change mid-run
    async_reset();
    dir = 1'b0; en = 1'b1;
    tick();
    chk("d2.down_first_out", 32'(d2_out), 32'd9);
    chk("d2.down_first_tc",  32'(d2_tc),  32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("d2.down_at5", 32'(d2_out), 32'd5);
    dir = 1'b1;
    tick();
    chk("d2.dir_up_6", 32'(d2_out), 32'd6);
    $display("dir toggle: d2.out=%0d", d2_out);

    // load, clamp, clear priority, load while disabled
    en = 1'b0; load = 1'b1; load_val = 16'd7;
    tick();
    chk("d1.load7", 32'(d1_out), 32'd7);
    load_val = 16'd14;
    tick();
    chk("d1.load_clamp", 32'(d1_out), 32'd9);
    chk("d0.load14", 32'(d0_out), 32'd14);
    clr = 1'b1;
    tick();
    chk("d1.clr_over_load", 32'(d1_out), 32'd0);
    clr = 1'b0; load = 1'b0;
    $display("load tests: d0.out=%0d d1.out=%0d", d0_out, d1_out);

    // enable freeze keeps partial prescale
    async_reset();
    en = 1'b1; dir = 1'b1;
    tick(); tick();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("d1.frozen_step", 32'(d1_step), 32'd0);
      chk("d1.frozen_out",  32'(d1_out),  32'd0);
    end
    en = 1'b1;
    tick();
    chk("d1.reenable_step", 32'(d1_step), 32'd1);
    chk("d1.reenable_out",  32'(d1_out),  32'd1);
    $display("enable freeze: d1.out=%0d step=%0d", d1_out, d1_step);

    // reset mid-prescale discards partial count
    en = 1'b0; load = 1'b1; load_val = 16'd6;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    chk("d1.pre_setup_out", 32'(d1_out), 32'd6);
    async_reset();
    chk("d1.async_out", 32'(d1_out), 32'd0);
    tick();
    chk("d1.post_rst_step1", 32'(d1_step), 32'd0);
    tick();
    chk("d1.post_rst_step2", 32'(d1_step), 32'd0);
    tick();
    chk("d1.post_rst_step3", 32'(d1_step), 32'd1);
    chk("d1.post_rst_out",   32'(d1_out),  32'd1);

    // randomized mix of all controls
    for (int i = 0; i < 4000; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      clr      = ($urandom_range(0, 39) == 0);
      load     = ($urandom_range(0, 19) == 0);
      dir      = $urandom_range(0, 1) == 1;
      load_val = 16'($urandom);
      if ($urandom_range(0, 499) == 0) async_reset();
      else tick();
    end
    $display("random phase done: d0.out=%0d d1.out=%0d d2.out=%0d", d0_out, d1_out, d2_out);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
